// File: rtl/decode_stage_mp_pkg.sv
// Shared decode definitions for decode_stage_mp: opcode and ALU enums, the
// control bundle carried to execute, register-count constants, and the
// control-unit / immediate-generator / operand-use helper functions.
// No ports (package).
package decode_stage_mp_pkg;

  localparam int NREGS_I = 32;  // RV32I register count
  localparam int NREGS_E = 16;  // RV32E register count

  typedef enum logic [6:0] {
    OPC_LUI    = 7'h37,
    OPC_AUIPC  = 7'h17,
    OPC_JAL    = 7'h6F,
    OPC_JALR   = 7'h67,
    OPC_BRANCH = 7'h63,
    OPC_LOAD   = 7'h03,
    OPC_STORE  = 7'h23,
    OPC_OP_IMM = 7'h13,
    OPC_OP     = 7'h33
  } opcode_t;

  localparam opcode_t LOAD_OPC = OPC_LOAD;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  typedef struct packed {
    logic    reg_write;
    logic    mem_write;
    alu_op_t alu_control;
    logic    alu_src;     // B operand is the immediate
    logic    alu_src_a;   // A operand is the PC
    logic    mem_to_reg;
    logic    branch;
    logic    jump;
    logic    jalr;
  } ctrl_t;

  function automatic logic opcode_known(opcode_t opc);
    logic k;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: k = 1'b1;
      default: k = 1'b0;
    endcase
    return k;
  endfunction

  // U and J types read no source registers.
  function automatic logic reads_rs1(opcode_t opc);
    return (opc == OPC_JALR) || (opc == OPC_BRANCH) || (opc == OPC_LOAD) ||
           (opc == OPC_STORE) || (opc == OPC_OP_IMM) || (opc == OPC_OP);
  endfunction

  function automatic logic reads_rs2(opcode_t opc);
    return (opc == OPC_BRANCH) || (opc == OPC_STORE) || (opc == OPC_OP);
  endfunction

  function automatic logic idx_ok(logic [4:0] idx, int nregs);
    return int'(idx) < nregs;
  endfunction

  // SUB only exists for register-register ops; SRA/SRAI share funct7[5].
  function automatic alu_op_t alu_decode(logic [2:0] f3, logic f7b5, logic is_reg);
    alu_op_t a;
    case (f3)
      3'b000:  a = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  a = ALU_SLL;
      3'b010:  a = ALU_SLT;
      3'b011:  a = ALU_SLTU;
      3'b100:  a = ALU_XOR;
      3'b101:  a = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  a = ALU_OR;
      default: a = ALU_AND;
    endcase
    return a;
  endfunction

  function automatic ctrl_t control_unit(opcode_t opc, logic [2:0] f3, logic f7b5);
    ctrl_t c;
    c = '0;
    c.alu_control = ALU_ADD;
    case (opc)
      OPC_OP: begin
        c.reg_write   = 1'b1;
        c.alu_control = alu_decode(f3, f7b5, 1'b1);
      end
      OPC_OP_IMM: begin
        c.reg_write   = 1'b1;
        c.alu_src     = 1'b1;
        c.alu_control = alu_decode(f3, f7b5, 1'b0);
      end
      OPC_LOAD: begin
        c.reg_write  = 1'b1;
        c.alu_src    = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      OPC_STORE: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OPC_BRANCH: begin
        c.branch      = 1'b1;
        c.alu_control = ALU_SUB;
      end
      OPC_JAL: begin
        c.reg_write = 1'b1;
        c.jump      = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_src_a = 1'b1;
      end
      OPC_JALR: begin
        c.reg_write = 1'b1;
        c.jump      = 1'b1;
        c.jalr      = 1'b1;
        c.alu_src   = 1'b1;
      end
      OPC_LUI: begin
        c.reg_write   = 1'b1;
        c.alu_src     = 1'b1;
        c.alu_control = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_src_a = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] imm_gen(opcode_t opc, logic [31:7] ib);
    logic [31:0] v;
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: v = {{20{ib[31]}}, ib[31:20]};
      OPC_STORE:  v = {{20{ib[31]}}, ib[31:25], ib[11:7]};
      OPC_BRANCH: v = {{19{ib[31]}}, ib[31], ib[7], ib[30:25], ib[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: v = {ib[31:12], 12'b0};
      OPC_JAL:    v = {{11{ib[31]}}, ib[31], ib[19:12], ib[20], ib[30:21], 1'b0};
      default:    v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/decode_stage_mp_if.sv
// Bundle of every decode-stage signal except clk/rst.
//   master : the surrounding pipeline (IF/ID producer, writeback, execute)
//   slave  : decode_stage_mp
// Handshakes (IF/ID in_* and ID/EX out_*): a transfer happens on a rising
// clock edge where valid && ready; the producer keeps valid and payload
// stable until that edge, and ready may depend combinationally on valid.
// pending is a read-only view of the load scoreboard (bit i = xi awaited).
interface decode_stage_mp_if
  import decode_stage_mp_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NWB  = 1
);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_instr;
  logic [XLEN-1:0]     in_pc;
  logic [NWB-1:0]      wb_we;
  logic [NWB*5-1:0]    wb_rd;
  logic [NWB*XLEN-1:0] wb_data;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_pc;
  logic [XLEN-1:0]     out_rs1_data;
  logic [XLEN-1:0]     out_rs2_data;
  logic [XLEN-1:0]     out_imm;
  logic [4:0]          out_rs1;
  logic [4:0]          out_rs2;
  logic [4:0]          out_rd;
  opcode_t             out_opcode;
  logic [2:0]          out_funct3;
  logic [6:0]          out_funct7;
  ctrl_t               out_ctrl;
  logic                out_illegal;
  logic [31:0]         pending;

  modport master (
    output in_valid, in_instr, in_pc, wb_we, wb_rd, wb_data, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
           out_rs1, out_rs2, out_rd, out_opcode, out_funct3, out_funct7,
           out_ctrl, out_illegal, pending
  );

  modport slave (
    input  in_valid, in_instr, in_pc, wb_we, wb_rd, wb_data, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
           out_rs1, out_rs2, out_rd, out_opcode, out_funct3, out_funct7,
           out_ctrl, out_illegal, pending
  );
endinterface

// File: rtl/decode_stage_mp_regfile.sv
// Multi-write-port register file (regfile_mp role) for decode_stage_mp.
// Ports: clk, rst (async, active-high); ra1/ra2 read indices, rd1/rd2
// combinational read data; we/wa/wd: NWB packed write ports.
// x0 reads 0 and ignores writes; indices >= NREGS read 0 and are not written.
// When two ports hit the same register the higher port index wins; with
// BYPASS != 0 a read of a register written this cycle returns that data.
module decode_stage_mp_regfile #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NWB    = 1,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          ra1,
  input  logic [4:0]          ra2,
  output logic [XLEN-1:0]     rd1,
  output logic [XLEN-1:0]     rd2,
  input  logic [NWB-1:0]      we,
  input  logic [NWB*5-1:0]    wa,
  input  logic [NWB*XLEN-1:0] wd
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs_q   [NREGS];
  logic [NREGS-1:0] hit;
  logic [XLEN-1:0]  hit_data [NREGS];
  logic [AW-1:0]    i1, i2;

  // Resolve the write ports per register; later ports overwrite earlier ones.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      hit[r]      = 1'b0;
      hit_data[r] = '0;
      for (int p = 0; p < NWB; p++) begin
        if (r != 0 && we[p] && wa[p*5 +: 5] == 5'(r)) begin
          hit[r]      = 1'b1;
          hit_data[r] = wd[p*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    i1  = ra1[AW-1:0];
    i2  = ra2[AW-1:0];
    rd1 = '0;
    rd2 = '0;
    if (int'(ra1) < NREGS) rd1 = (BYPASS != 0 && hit[i1]) ? hit_data[i1] : regs_q[i1];
    if (int'(ra2) < NREGS) rd2 = (BYPASS != 0 && hit[i2]) ? hit_data[i2] : regs_q[i2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (hit[r]) regs_q[r] <= hit_data[r];
      end
    end
  end
endmodule

// File: rtl/decode_stage_mp.sv
// RV32I/RV32E decode stage with a registered ID/EX slot, a multi-port
// register file and a load scoreboard that stalls load-use consumers.
// Ports: clk, rst (async, active-high); bus (decode_stage_mp_if.slave):
// IF/ID in_* handshake, wb_* writeback ports, flush, ID/EX out_* handshake
// and decode results, pending scoreboard view.
module decode_stage_mp
  import decode_stage_mp_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = NREGS_I,
  parameter int NWB    = 1,
  parameter int BYPASS = 1
) (
  input logic              clk,
  input logic              rst,
  decode_stage_mp_if.slave bus
);
  // Scoreboard bits that exist: x1..x(NREGS-1).
  localparam logic [31:0] REG_MASK =
    ((NREGS >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NREGS) - 32'd1)) & ~32'd1;

  logic [31:0]     instr;
  opcode_t         opc;
  logic [4:0]      rs1, rs2, rd;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic            use_rs1, use_rs2, idx_bad, illegal, is_load;
  ctrl_t           ctrl_raw, ctrl;
  logic [XLEN-1:0] imm, rs1_data, rs2_data;
  logic [31:0]     pending_q, pending_d, wb_clr, pend_view, set_mask, retract_mask;
  logic            hazard, ready, take;

  always_comb begin
    instr    = bus.in_instr;
    opc      = opcode_t'(instr[6:0]);
    rd       = instr[11:7];
    f3       = instr[14:12];
    rs1      = instr[19:15];
    rs2      = instr[24:20];
    f7       = instr[31:25];
    use_rs1  = reads_rs1(opc);
    use_rs2  = reads_rs2(opc);
    ctrl_raw = control_unit(opc, f3, f7[5]);
    // Only indices the instruction actually uses can make it illegal.
    idx_bad  = (use_rs1 && !idx_ok(rs1, NREGS)) || (use_rs2 && !idx_ok(rs2, NREGS)) ||
               (ctrl_raw.reg_write && !idx_ok(rd, NREGS));
    illegal  = !opcode_known(opc) || idx_bad;
    ctrl     = illegal ? '0 : ctrl_raw;
    is_load  = (opc == LOAD_OPC) && !illegal;
    imm      = XLEN'($signed(imm_gen(opc, instr[31:7])));
  end

  decode_stage_mp_regfile #(
    .XLEN(XLEN), .NREGS(NREGS), .NWB(NWB), .BYPASS(BYPASS)
  ) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (rs1_data),
    .rd2 (rs2_data),
    .we  (bus.wb_we),
    .wa  (bus.wb_rd),
    .wd  (bus.wb_data)
  );

  always_comb begin
    wb_clr = '0;
    for (int p = 0; p < NWB; p++) begin
      if (bus.wb_we[p]) wb_clr[bus.wb_rd[p*5 +: 5]] = 1'b1;
    end
    wb_clr = wb_clr & REG_MASK;

    // With bypass the arriving load data is forwarded, so its clear releases
    // the consumer in the same cycle; without bypass it waits one more cycle.
    pend_view = (BYPASS != 0) ? (pending_q & ~wb_clr) : pending_q;
    hazard    = bus.in_valid && ((use_rs1 && pend_view[rs1]) || (use_rs2 && pend_view[rs2]));
    ready     = (!bus.out_valid || bus.out_ready) && !hazard;
    // An accept coinciding with flush is wrong-path and is dropped.
    take      = bus.in_valid && ready && !bus.flush;

    set_mask = '0;
    if (take && is_load) set_mask[rd] = 1'b1;
    set_mask = set_mask & REG_MASK;

    // A killed slot load will never write back, so forget its pending bit.
    retract_mask = '0;
    if (bus.flush && bus.out_valid && bus.out_opcode == LOAD_OPC && !bus.out_illegal)
      retract_mask[bus.out_rd] = 1'b1;

    // Set is applied last so it wins over a same-cycle clear.
    pending_d = ((pending_q & ~wb_clr & ~retract_mask) | set_mask) & REG_MASK;
  end

  assign bus.in_ready = ready;
  assign bus.pending  = pending_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q        <= '0;
      bus.out_valid    <= 1'b0;
      bus.out_pc       <= '0;
      bus.out_rs1_data <= '0;
      bus.out_rs2_data <= '0;
      bus.out_imm      <= '0;
      bus.out_rs1      <= '0;
      bus.out_rs2      <= '0;
      bus.out_rd       <= '0;
      bus.out_opcode   <= opcode_t'(7'd0);
      bus.out_funct3   <= '0;
      bus.out_funct7   <= '0;
      bus.out_ctrl     <= '0;
      bus.out_illegal  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (bus.flush) begin
        bus.out_valid <= 1'b0;
      end else if (take) begin
        bus.out_valid    <= 1'b1;
        bus.out_pc       <= bus.in_pc;
        bus.out_rs1_data <= rs1_data;
        bus.out_rs2_data <= rs2_data;
        bus.out_imm      <= imm;
        bus.out_rs1      <= rs1;
        bus.out_rs2      <= rs2;
        bus.out_rd       <= rd;
        bus.out_opcode   <= opc;
        bus.out_funct3   <= f3;
        bus.out_funct7   <= f7;
        bus.out_ctrl     <= ctrl;
        bus.out_illegal  <= illegal;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_decode_stage_mp.sv
// Directed bench for decode_stage_mp. Instance a: RV32I, 2 writeback ports,
// bypass on. Instance b: RV32E, 1 writeback port, bypass off.
module tb_decode_stage_mp;
  import decode_stage_mp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_mp_if #(.XLEN(32), .NWB(2)) a_if ();
  decode_stage_mp_if #(.XLEN(32), .NWB(1)) b_if ();

  decode_stage_mp #(.XLEN(32), .NREGS(NREGS_I), .NWB(2), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if)
  );
  decode_stage_mp #(.XLEN(32), .NREGS(NREGS_E), .NWB(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  ctrl_t exp_ctrl;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_if.in_valid = 1'b0;
    a_if.wb_we    = '0;
    a_if.flush    = 1'b0;
  endtask

  task automatic b_idle();
    b_if.in_valid = 1'b0;
    b_if.wb_we    = '0;
    b_if.flush    = 1'b0;
  endtask

  function automatic logic [31:0] enc_add(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(logic [6:0] opc, logic [2:0] f3, logic [4:0] rd,
                                        logic [4:0] rs1, logic [11:0] imm);
    return {imm, rs1, f3, rd, opc};
  endfunction

  initial begin
    rst = 1'b1;
    a_idle(); b_idle();
    a_if.in_instr = '0; a_if.in_pc = '0; a_if.wb_rd = '0; a_if.wb_data = '0; a_if.out_ready = 1'b1;
    b_if.in_instr = '0; b_if.in_pc = '0; b_if.wb_rd = '0; b_if.wb_data = '0; b_if.out_ready = 1'b1;
    tick(); tick();
    chk("reset_out_valid", 64'(a_if.out_valid), 64'd0);
    chk("reset_out_imm", 64'(a_if.out_imm), 64'd0);
    chk("reset_out_rd", 64'(a_if.out_rd), 64'd0);
    chk("reset_pending", 64'(a_if.pending), 64'd0);
    rst = 1'b0;
    tick();
    chk("reset_in_ready", 64'(a_if.in_ready), 64'd1);

    // addi x1,x0,5
    a_if.in_valid = 1'b1; a_if.in_instr = enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd5); a_if.in_pc = 32'h100;
    tick();
    a_idle();
    exp_ctrl = '0; exp_ctrl.reg_write = 1'b1; exp_ctrl.alu_src = 1'b1; exp_ctrl.alu_control = ALU_ADD;
    chk("addi_valid", 64'(a_if.out_valid), 64'd1);
    chk("addi_imm", 64'(a_if.out_imm), 64'd5);
    chk("addi_rd", 64'(a_if.out_rd), 64'd1);
    chk("addi_rs1_data", 64'(a_if.out_rs1_data), 64'd0);
    chk("addi_pc", 64'(a_if.out_pc), 64'h100);
    chk("addi_opcode", 64'(a_if.out_opcode), 64'h13);
    chk("addi_ctrl", 64'(a_if.out_ctrl), 64'(exp_ctrl));
    chk("addi_illegal", 64'(a_if.out_illegal), 64'd0);
    tick();
    chk("drain_valid", 64'(a_if.out_valid), 64'd0);

    // lw x3,0(x2) then add x4,x3,x3 stalls until the x3 writeback
    a_if.in_valid = 1'b1; a_if.in_instr = enc_i(7'h03, 3'd2, 5'd3, 5'd2, 12'd0);
    tick();
    chk("lw_pending", 64'(a_if.pending), 64'h8);
    chk("lw_mem_to_reg", 64'(a_if.out_ctrl.mem_to_reg), 64'd1);
    a_if.in_instr = enc_add(5'd4, 5'd3, 5'd3);
    #1 chk("loaduse_stall0", 64'(a_if.in_ready), 64'd0);
    tick();
    chk("loaduse_stall1", 64'(a_if.in_ready), 64'd0);
    chk("loaduse_slot_empty", 64'(a_if.out_valid), 64'd0);
    a_if.wb_we = 2'b01; a_if.wb_rd = {5'd0, 5'd3}; a_if.wb_data = {32'd0, 32'h77};
    #1 chk("loaduse_release", 64'(a_if.in_ready), 64'd1);
    tick();
    a_idle();
    chk("loaduse_valid", 64'(a_if.out_valid), 64'd1);
    chk("loaduse_rs1", 64'(a_if.out_rs1_data), 64'h77);
    chk("loaduse_rs2", 64'(a_if.out_rs2_data), 64'h77);
    chk("loaduse_rd", 64'(a_if.out_rd), 64'd4);
    chk("loaduse_pending", 64'(a_if.pending), 64'd0);

    // Both ports write x5; port 1 wins for bypass and for storage
    a_if.in_valid = 1'b1; a_if.in_instr = enc_add(5'd6, 5'd5, 5'd0);
    a_if.wb_we = 2'b11; a_if.wb_rd = {5'd5, 5'd5}; a_if.wb_data = {32'h22, 32'h11};
    tick();
    chk("dualwb_rs1", 64'(a_if.out_rs1_data), 64'h22);
    chk("dualwb_rs2_x0", 64'(a_if.out_rs2_data), 64'd0);
    a_if.in_instr = enc_add(5'd9, 5'd0, 5'd5);
    a_if.wb_we = 2'b01; a_if.wb_rd = {5'd0, 5'd0}; a_if.wb_data = {32'd0, 32'hFF};
    tick();
    a_if.wb_we = '0;
    chk("x0_write_dropped", 64'(a_if.out_rs1_data), 64'd0);
    chk("x5_stored", 64'(a_if.out_rs2_data), 64'h22);

    // Back-pressure: slot holds add x9 for 3 cycles
    a_if.out_ready = 1'b0;
    a_if.in_instr = enc_i(7'h13, 3'd0, 5'd10, 5'd0, 12'h123);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", 64'(a_if.in_ready), 64'd0);
      tick();
      chk("bp_valid", 64'(a_if.out_valid), 64'd1);
      chk("bp_rd_held", 64'(a_if.out_rd), 64'd9);
      chk("bp_rs2_held", 64'(a_if.out_rs2_data), 64'h22);
    end
    a_if.out_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(a_if.in_ready), 64'd1);
    tick();
    a_idle();
    chk("bp_next_rd", 64'(a_if.out_rd), 64'd10);
    chk("bp_next_imm", 64'(a_if.out_imm), 64'h123);
    tick();
    chk("bp_drain", 64'(a_if.out_valid), 64'd0);

    // Flush a held lw x7: pending retracted, dependent add accepted at once
    a_if.in_valid = 1'b1; a_if.in_instr = enc_i(7'h03, 3'd2, 5'd7, 5'd0, 12'd0);
    tick();
    chk("lw7_pending", 64'(a_if.pending), 64'h80);
    a_if.in_valid = 1'b0; a_if.out_ready = 1'b0; a_if.flush = 1'b1;
    tick();
    a_if.flush = 1'b0; a_if.out_ready = 1'b1;
    chk("flush_valid", 64'(a_if.out_valid), 64'd0);
    chk("flush_retract", 64'(a_if.pending), 64'd0);
    a_if.in_valid = 1'b1; a_if.in_instr = enc_add(5'd8, 5'd7, 5'd7);
    #1 chk("flush_nostall", 64'(a_if.in_ready), 64'd1);
    tick();
    chk("add8_valid", 64'(a_if.out_valid), 64'd1);
    chk("add8_rd", 64'(a_if.out_rd), 64'd8);
    // Accept in a flush cycle is discarded
    a_if.in_instr = enc_i(7'h13, 3'd0, 5'd11, 5'd0, 12'd1); a_if.flush = 1'b1;
    tick();
    a_idle();
    chk("flush_discard", 64'(a_if.out_valid), 64'd0);

    // Load set and writeback clear of the same rd in one cycle: set wins
    a_if.in_valid = 1'b1; a_if.in_instr = enc_i(7'h03, 3'd2, 5'd12, 5'd0, 12'd0);
    a_if.wb_we = 2'b01; a_if.wb_rd = {5'd0, 5'd12}; a_if.wb_data = {32'd0, 32'h5};
    tick();
    a_if.in_valid = 1'b0;
    chk("set_wins", 64'(a_if.pending), 64'h1000);
    tick();
    a_idle();
    chk("wb_clears", 64'(a_if.pending), 64'd0);

    // Reset in the middle of a load-use stall
    a_if.in_valid = 1'b1; a_if.in_instr = enc_i(7'h03, 3'd2, 5'd13, 5'd0, 12'd0);
    tick();
    a_if.in_instr = enc_add(5'd14, 5'd13, 5'd13);
    #1 chk("pre_reset_stall", 64'(a_if.in_ready), 64'd0);
    #1 rst = 1'b1;
    #1;
    chk("midreset_valid", 64'(a_if.out_valid), 64'd0);
    chk("midreset_pending", 64'(a_if.pending), 64'd0);
    chk("midreset_ready", 64'(a_if.in_ready), 64'd1);
    a_idle();
    tick();
    rst = 1'b0;
    tick();

    // RV32E, no bypass
    b_if.in_valid = 1'b1; b_if.in_instr = enc_add(5'd17, 5'd1, 5'd2);
    tick();
    chk("e_bad_rd_valid", 64'(b_if.out_valid), 64'd1);
    chk("e_bad_rd_illegal", 64'(b_if.out_illegal), 64'd1);
    chk("e_bad_rd_ctrl", 64'(b_if.out_ctrl), 64'd0);
    chk("e_bad_rd_rd", 64'(b_if.out_rd), 64'd17);
    b_if.in_instr = 32'h0000_007F;
    tick();
    chk("bad_opc_illegal", 64'(b_if.out_illegal), 64'd1);
    chk("bad_opc_ctrl", 64'(b_if.out_ctrl), 64'd0);
    chk("bad_opc_opcode", 64'(b_if.out_opcode), 64'h7F);
    b_if.in_instr = enc_add(5'd3, 5'd1, 5'd1);
    b_if.wb_we = 1'b1; b_if.wb_rd = 5'd1; b_if.wb_data = 32'h55;
    tick();
    b_if.wb_we = 1'b0;
    chk("nobyp_legal", 64'(b_if.out_illegal), 64'd0);
    chk("nobyp_old", 64'(b_if.out_rs1_data), 64'd0);
    tick();
    chk("nobyp_next", 64'(b_if.out_rs1_data), 64'h55);
    b_if.in_instr = enc_i(7'h03, 3'd2, 5'd2, 5'd0, 12'd0);
    tick();
    chk("e_lw_pending", 64'(b_if.pending), 64'h4);
    b_if.in_instr = enc_add(5'd4, 5'd2, 5'd2);
    b_if.wb_we = 1'b1; b_if.wb_rd = 5'd2; b_if.wb_data = 32'h66;
    #1 chk("nobyp_stall_wb_cycle", 64'(b_if.in_ready), 64'd0);
    tick();
    b_if.wb_we = 1'b0;
    #1 chk("nobyp_release", 64'(b_if.in_ready), 64'd1);
    tick();
    b_idle();
    chk("nobyp_lu_valid", 64'(b_if.out_valid), 64'd1);
    chk("nobyp_lu_rs1", 64'(b_if.out_rs1_data), 64'h66);
    chk("nobyp_lu_rd", 64'(b_if.out_rd), 64'd4);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
